// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames one byte per accept as start, 5-8 data
// bits LSB first, optional parity and one or two stop bits. Bit timing
// comes from an external oversampling tick (bclk_in), OVERSAMPLE ticks per bit.
module uart_tx_serializer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       bclk_in,
    input  logic [7:0] tx_data_in,
    input  logic       tx_valid_in,
    output logic       tx_ready_out,
    input  logic [1:0] wlen_in,
    input  logic       parity_en_in,
    input  logic       parity_odd_in,
    input  logic       stop2_in,
    output logic       txd_out,
    output logic       busy_out,
    output logic       done_out
);

    localparam int         DATA_W    = 8;
    localparam logic [5:0] TICK_LAST = 6'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t              state_q, state_nxt;
    logic [5:0]          tick_q, tick_nxt;
    logic [2:0]          bit_q, bit_nxt;
    logic [DATA_W-1:0]   data_q;
    logic [2:0]          last_q;
    logic                par_en_q, par_q, stop2_q;
    logic                txd_q, txd_nxt;
    logic                ready_q, busy_q, done_q, done_nxt;
    logic                accept, period_end;

    // Parity over the active data bits only; bits above the word length are masked out.
    function automatic logic parity_of(input logic [DATA_W-1:0] d, input logic [1:0] wl,
                                       input logic odd);
        logic [DATA_W-1:0] mask;
        case (wl)
            2'b00:   mask = 8'h1F;
            2'b01:   mask = 8'h3F;
            2'b10:   mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        return (^(d & mask)) ^ odd;
    endfunction

    assign accept     = tx_valid_in && ready_q;
    assign period_end = bclk_in && (tick_q == TICK_LAST);

    // Next-state, counter and serial-line value; txd is computed from the
    // next state so the registered line changes on the same edge as the state.
    always_comb begin
        state_nxt = state_q;
        tick_nxt  = tick_q;
        bit_nxt   = bit_q;
        done_nxt  = 1'b0;
        txd_nxt   = 1'b1;

        if (state_q != IDLE && bclk_in) begin
            tick_nxt = period_end ? 6'd0 : tick_q + 6'd1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_nxt = START;
                    tick_nxt  = 6'd0;
                    bit_nxt   = 3'd0;
                end
            end
            START: begin
                if (period_end) state_nxt = DATA;
            end
            DATA: begin
                if (period_end) begin
                    if (bit_q == last_q) begin
                        bit_nxt   = 3'd0;
                        state_nxt = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_nxt = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (period_end) begin
                    bit_nxt   = 3'd0;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (period_end) begin
                    if (bit_q == {2'b00, stop2_q}) begin
                        bit_nxt   = 3'd0;
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        bit_nxt = bit_q + 3'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            START:   txd_nxt = 1'b0;
            DATA:    txd_nxt = data_q[bit_nxt];
            PARITY:  txd_nxt = par_q;
            default: txd_nxt = 1'b1;
        endcase
    end

    // Control state register with synchronous reset; a reset aborts any frame silently.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            tick_q  <= 6'd0;
            bit_q   <= 3'd0;
            txd_q   <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            tick_q  <= tick_nxt;
            bit_q   <= bit_nxt;
            txd_q   <= txd_nxt;
            ready_q <= (state_nxt == IDLE);
            busy_q  <= (state_nxt != IDLE);
            done_q  <= done_nxt;
        end
    end

    // Frame data and configuration snapshot taken at accept; held for the whole frame.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            data_q   <= tx_data_in;
            last_q   <= 3'd4 + {1'b0, wlen_in};
            par_en_q <= parity_en_in;
            par_q    <= parity_of(tx_data_in, wlen_in, parity_odd_in);
            stop2_q  <= stop2_in;
        end
    end

    assign tx_ready_out = ready_q;
    assign busy_out     = busy_q;
    assign done_out     = done_q;
    assign txd_out      = txd_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: each frame is checked cycle by
// cycle against a hand-written bit sequence with OVERSAMPLE=16.
module tb_uart_tx_serializer;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       bclk_in;
    logic [7:0] tx_data_in;
    logic       tx_valid_in;
    logic       tx_ready_out;
    logic [1:0] wlen_in;
    logic       parity_en_in;
    logic       parity_odd_in;
    logic       stop2_in;
    logic       txd_out;
    logic       busy_out;
    logic       done_out;

    int total = 0;
    int bad   = 0;

    uart_tx_serializer #(.OVERSAMPLE(16)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .bclk_in       (bclk_in),
        .tx_data_in    (tx_data_in),
        .tx_valid_in   (tx_valid_in),
        .tx_ready_out  (tx_ready_out),
        .wlen_in       (wlen_in),
        .parity_en_in  (parity_en_in),
        .parity_odd_in (parity_odd_in),
        .stop2_in      (stop2_in),
        .txd_out       (txd_out),
        .busy_out      (busy_out),
        .done_out      (done_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one frame and checks txd/done every cycle. bclk pulses when the
    // count of ungated cycles since accept is a multiple of div, so every bit
    // spans exactly 16*div ungated cycles. chain: inputs already set by the
    // previous frame (accept on the next edge). hold: keep valid high and
    // present the next frame's byte/config right after accept.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] wl,
                             input logic pen, input logic podd, input logic st2,
                             input int div, input logic [11:0] exp_bits, input int nbits,
                             input bit chain, input bit hold,
                             input logic [7:0] nd, input logic [1:0] nwl,
                             input logic npen, input logic npodd, input logic nst2,
                             input int gate_at, input int gate_len, input int abort_at);
        int k;
        int g;
        int per;
        per = 16 * div;
        if (!chain) begin
            tx_data_in    = d;
            wlen_in       = wl;
            parity_en_in  = pen;
            parity_odd_in = podd;
            stop2_in      = st2;
            tx_valid_in   = 1'b1;
        end
        bclk_in = 1'b0;
        @(negedge clk_in);
        if (hold) begin
            tx_data_in    = nd;
            wlen_in       = nwl;
            parity_en_in  = npen;
            parity_odd_in = npodd;
            stop2_in      = nst2;
            tx_valid_in   = 1'b1;
        end else begin
            tx_data_in    = ~d;
            wlen_in       = ~wl;
            parity_en_in  = ~pen;
            parity_odd_in = ~podd;
            stop2_in      = ~st2;
            tx_valid_in   = 1'b0;
        end
        chk({tag, ".busy_start"}, 32'(busy_out), 32'd1);
        chk({tag, ".ready_start"}, 32'(tx_ready_out), 32'd0);
        k = 0;
        g = 0;
        while (k < nbits * per) begin
            chk({tag, ".txd"}, 32'(txd_out), 32'(exp_bits[k / per]));
            chk({tag, ".done_low"}, 32'(done_out), 32'd0);
            if (k == abort_at) begin
                rst_in  = 1'b1;
                bclk_in = 1'b1;
                @(negedge clk_in);
                chk({tag, ".abort_txd"}, 32'(txd_out), 32'd1);
                chk({tag, ".abort_busy"}, 32'(busy_out), 32'd0);
                chk({tag, ".abort_done"}, 32'(done_out), 32'd0);
                chk({tag, ".abort_ready"}, 32'(tx_ready_out), 32'd0);
                rst_in  = 1'b0;
                bclk_in = 1'b0;
                @(negedge clk_in);
                chk({tag, ".abort_ready_after"}, 32'(tx_ready_out), 32'd1);
                chk({tag, ".abort_done_after"}, 32'(done_out), 32'd0);
                chk({tag, ".abort_txd_after"}, 32'(txd_out), 32'd1);
                return;
            end
            if (gate_len > 0 && k == gate_at && g < gate_len) begin
                bclk_in = 1'b0;
                g++;
            end else begin
                k++;
                bclk_in = ((k % div) == 0);
            end
            @(negedge clk_in);
        end
        bclk_in = 1'b0;
        chk({tag, ".done_pulse"}, 32'(done_out), 32'd1);
        chk({tag, ".ready_end"}, 32'(tx_ready_out), 32'd1);
        chk({tag, ".busy_end"}, 32'(busy_out), 32'd0);
        chk({tag, ".txd_idle"}, 32'(txd_out), 32'd1);
        chk({tag, ".gate_used"}, 32'(g), 32'(gate_len));
    endtask

    initial begin
        rst_in        = 1'b1;
        bclk_in       = 1'b0;
        tx_data_in    = 8'h00;
        tx_valid_in   = 1'b0;
        wlen_in       = 2'b11;
        parity_en_in  = 1'b0;
        parity_odd_in = 1'b0;
        stop2_in      = 1'b0;

        // reset state
        repeat (3) @(negedge clk_in);
        chk("rst.txd", 32'(txd_out), 32'd1);
        chk("rst.busy", 32'(busy_out), 32'd0);
        chk("rst.done", 32'(done_out), 32'd0);
        chk("rst.ready", 32'(tx_ready_out), 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("rst.ready_after", 32'(tx_ready_out), 32'd1);
        chk("rst.busy_after", 32'(busy_out), 32'd0);

        // 0x55 8N1, tick every cycle: 0,1,0,1,0,1,0,1,0,1
        run_frame("f55_8n1", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1, 12'h2AA, 10,
                  1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, -1);

        // 0xA3 5 bits even parity 2 stop: 0,1,1,0,0,0,0,1,1
        run_frame("fA3_5e2", 8'hA3, 2'b00, 1'b1, 1'b0, 1'b1, 1, 12'h186, 9,
                  1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, -1);

        // 0x07 8 bits odd parity -> parity 0; even parity -> parity 1
        run_frame("f07_8o1", 8'h07, 2'b11, 1'b1, 1'b1, 1'b0, 1, 12'h40E, 11,
                  1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, -1);
        run_frame("f07_8e1", 8'h07, 2'b11, 1'b1, 1'b0, 1'b0, 1, 12'h60E, 11,
                  1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, -1);

        // back-to-back with valid held: 0x3C 8N1 then 0xC5 7 bits odd parity 1 stop
        run_frame("b2b_first", 8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1, 12'h278, 10,
                  1'b0, 1'b1, 8'hC5, 2'b10, 1'b1, 1'b1, 1'b0, 0, 0, -1);
        run_frame("b2b_second", 8'hC5, 2'b10, 1'b1, 1'b1, 1'b0, 1, 12'h28A, 10,
                  1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, -1);

        // tick every 5 cycles, gated off 100 cycles in DATA: 0x96 8N1
        run_frame("f96_gated", 8'h96, 2'b11, 1'b0, 1'b0, 1'b0, 5, 12'h32C, 10,
                  1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 260, 100, -1);

        // reset during data bit 3, then a clean 0x0F 6 bits even parity frame
        run_frame("abort", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1, 12'h2AA, 10,
                  1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, 69);
        run_frame("f0F_6e1", 8'h0F, 2'b01, 1'b1, 1'b0, 1'b0, 1, 12'h11E, 9,
                  1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 0, 0, -1);

        @(negedge clk_in);
        chk("final.done_low", 32'(done_out), 32'd0);
        chk("final.ready", 32'(tx_ready_out), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
